// File: rtl/spi_sram_pkg.sv
// Shared constants and state encoding for the SPI-to-SRAM bridge.
package spi_sram_pkg;

    localparam int HDR_BITS = 24;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;

    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_RD_ACC   = 3'd2,
        ST_RD_OUT   = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_WR_PULSE = 3'd5,
        ST_IGNORE   = 3'd6
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and flags sclk/csn edges.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic csn,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic csn_s,
    output logic mosi_s
);

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic csn_meta_q, csn_sync_q, csn_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic sclk_meta_d, sclk_sync_d, sclk_prev_d;
    logic csn_meta_d, csn_sync_d, csn_prev_d;
    logic mosi_meta_d, mosi_sync_d;

    // Next values of the two-stage synchronisers plus one history stage for edges.
    always_comb begin
        sclk_meta_d = sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        csn_meta_d  = csn;
        csn_sync_d  = csn_meta_q;
        csn_prev_d  = csn_sync_q;
        mosi_meta_d = mosi;
        mosi_sync_d = mosi_meta_q;
    end

    // csn stages clear to 0 so a frame can only start after csn has been seen
    // high, which discards a frame that was in flight across a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            csn_meta_q  <= 1'b0;
            csn_sync_q  <= 1'b0;
            csn_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            csn_meta_q  <= csn_meta_d;
            csn_sync_q  <= csn_sync_d;
            csn_prev_q  <= csn_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign csn_fall  = ~csn_sync_q & csn_prev_q;
    assign csn_rise  = csn_sync_q & ~csn_prev_q;
    assign csn_s     = csn_sync_q;
    assign mosi_s    = mosi_sync_q;

endmodule

// File: rtl/spi_sram_bridge.sv
// SPI slave that turns 24-bit read/write headers into single-byte SRAM cycles.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | waiting for csn fall, SRAM controls released
//   ST_HDR      | shifting in {cmd, pad, addr}, one bit per sclk rise
//   ST_RD_ACC   | cen/oen low for RD_WAIT clks, then byte latched
//   ST_RD_OUT   | latched byte shifted onto miso on sclk falls
//   ST_WR_DATA  | shifting in the write byte on sclk rises
//   ST_WR_PULSE | bus driven, cen low WR_PULSE+2 clks with wen in the middle
//   ST_IGNORE   | frame finished or unsupported cmd; wait for csn rise
module spi_sram_bridge
    import spi_sram_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic              cen,
    output logic              oen,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    localparam int TMR_W = 8;
    localparam logic [5:0] LAST_HDR_BIT  = 6'(HDR_BITS - 1);
    localparam logic [5:0] LAST_DATA_BIT = 6'(HDR_BITS + DATA_W - 1);

    logic sclk_rise, sclk_fall, csn_fall, csn_rise, csn_s, mosi_s;

    state_t              state_q, state_d;
    logic [HDR_BITS-2:0] shift_q, shift_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DATA_W-1:0]   dbyte_q, dbyte_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cen_q, cen_d;
    logic                oen_q, oen_d;
    logic                wen_q, wen_d;
    logic                drive_q, drive_d;
    logic                miso_q, miso_d;

    spi_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .csn       (csn),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .csn_s     (csn_s),
        .mosi_s    (mosi_s)
    );

    // Frame sequencing, SRAM strobe timing and miso shifting.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        dbyte_d   = dbyte_q;
        addr_d    = addr_q;
        cen_d     = cen_q;
        oen_d     = oen_q;
        wen_d     = wen_q;
        drive_d   = drive_q;
        miso_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cen_d   = 1'b1;
                oen_d   = 1'b1;
                wen_d   = 1'b1;
                drive_d = 1'b0;
                if (csn_fall) begin
                    state_d   = ST_HDR;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end

            ST_HDR: begin
                if (csn_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[HDR_BITS-3:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == LAST_HDR_BIT) begin
                        // shift_q still lacks the final bit: cmd sits in the
                        // top two bits, the address completes with mosi_s.
                        if (shift_q[HDR_BITS-2 -: 2] == CMD_READ) begin
                            state_d = ST_RD_ACC;
                            addr_d  = {shift_q[ADDR_W-2:0], mosi_s};
                        end else if (shift_q[HDR_BITS-2 -: 2] == CMD_WRITE) begin
                            state_d = ST_WR_DATA;
                            addr_d  = {shift_q[ADDR_W-2:0], mosi_s};
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end

            ST_RD_ACC: begin
                if (csn_rise) begin
                    state_d = ST_IDLE;
                    cen_d   = 1'b1;
                    oen_d   = 1'b1;
                end else if (cen_q) begin
                    cen_d = 1'b0;
                    oen_d = 1'b0;
                    tmr_d = TMR_W'(RD_WAIT - 1);
                end else if (tmr_q == '0) begin
                    dbyte_d = data;
                    cen_d   = 1'b1;
                    oen_d   = 1'b1;
                    state_d = ST_RD_OUT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_RD_OUT: begin
                miso_d = miso_q;
                if (csn_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else begin
                    if (sclk_fall) begin
                        miso_d  = dbyte_q[DATA_W-1];
                        dbyte_d = {dbyte_q[DATA_W-2:0], 1'b0};
                    end
                    // Leave only once the master has sampled the last bit.
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            state_d = ST_IGNORE;
                            miso_d  = 1'b0;
                        end
                    end
                end
            end

            ST_WR_DATA: begin
                if (csn_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    dbyte_d   = {dbyte_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = ST_WR_PULSE;
                    end
                end
            end

            ST_WR_PULSE: begin
                // csn is not an abort here: a started write always completes.
                if (cen_q) begin
                    cen_d   = 1'b0;
                    drive_d = 1'b1;
                    wen_d   = 1'b1;
                    tmr_d   = TMR_W'(WR_PULSE + 1);
                end else if (tmr_q == '0) begin
                    cen_d   = 1'b1;
                    wen_d   = 1'b1;
                    drive_d = 1'b0;
                    state_d = csn_s ? ST_IDLE : ST_IGNORE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                    wen_d = !((tmr_q >= TMR_W'(2)) && (tmr_q <= TMR_W'(WR_PULSE + 1)));
                end
            end

            ST_IGNORE: begin
                cen_d   = 1'b1;
                oen_d   = 1'b1;
                wen_d   = 1'b1;
                drive_d = 1'b0;
                if (csn_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cen_d   = 1'b1;
                oen_d   = 1'b1;
                wen_d   = 1'b1;
                drive_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            dbyte_q   <= '0;
            addr_q    <= '0;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
            drive_q   <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            dbyte_q   <= dbyte_d;
            addr_q    <= addr_d;
            cen_q     <= cen_d;
            oen_q     <= oen_d;
            wen_q     <= wen_d;
            drive_q   <= drive_d;
            miso_q    <= miso_d;
        end
    end

    assign miso = miso_q;
    assign cen  = cen_q;
    assign oen  = oen_q;
    assign wen  = wen_q;
    assign addr = addr_q;
    assign data = drive_q ? dbyte_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Scoreboard bench: stimulus queues expected SRAM cycles and miso bytes,
// monitors pop and compare as the DUT produces them.
module tb_spi_sram_bridge;
    import spi_sram_pkg::*;

    localparam int HALF = 8;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sclk = 1'b0;
    logic        csn  = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, cen, oen, wen;
    logic [16:0] addr;
    wire  [7:0]  data;
    logic [7:0]  sram_byte = 8'h00;

    assign data = (!cen && !oen && wen) ? sram_byte : 8'hzz;

    always #5 clk = ~clk;

    spi_sram_bridge #(.RD_WAIT(2), .WR_PULSE(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .csn  (csn),
        .mosi (mosi),
        .miso (miso),
        .cen  (cen),
        .oen  (oen),
        .wen  (wen),
        .addr (addr),
        .data (data)
    );

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        int          width;
    } acc_t;

    acc_t       rd_q[$];
    acc_t       wr_q[$];
    logic [7:0] rx_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         exp_acc = 0;
    int         cen_falls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] hdr(input logic [1:0] cmd, input logic [4:0] pad, input logic [16:0] a);
        return {cmd, pad, a};
    endfunction

    // Read strobe monitor: one entry per oen-low window.
    int          rd_w = 0;
    logic [16:0] rd_addr;
    bit          rd_ok;
    acc_t        rd_e;
    always @(negedge clk) begin
        if (oen === 1'b0) begin
            if (rd_w == 0) begin
                rd_addr = addr;
                rd_ok   = 1'b1;
            end
            rd_w++;
            if (addr !== rd_addr || cen !== 1'b0 || wen !== 1'b1) rd_ok = 1'b0;
        end else if (rd_w != 0) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                rd_e = rd_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(rd_e.addr));
                check("rd_width", 32'(rd_w), 32'(rd_e.width));
                check("rd_ctrl_stable", 32'(rd_ok), 32'd1);
            end
            rd_w = 0;
        end
    end

    // Write strobe monitor: one entry per wen-low window.
    int          wr_w = 0;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    bit          wr_ok;
    acc_t        wr_e;
    always @(negedge clk) begin
        if (wen === 1'b0) begin
            if (wr_w == 0) begin
                wr_addr = addr;
                wr_data = data;
                wr_ok   = 1'b1;
            end
            wr_w++;
            if (addr !== wr_addr || data !== wr_data || cen !== 1'b0 || oen !== 1'b1) wr_ok = 1'b0;
        end else if (wr_w != 0) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(wr_e.addr));
                check("wr_data", 32'(wr_data), 32'(wr_e.data));
                check("wr_width", 32'(wr_w), 32'(wr_e.width));
                check("wr_bus_stable", 32'(wr_ok), 32'd1);
            end
            wr_w = 0;
        end
    end

    // Counts SRAM cycles of any kind via cen falls.
    logic cen_prev = 1'b1;
    always @(negedge clk) begin
        if (cen === 1'b0 && cen_prev === 1'b1) cen_falls++;
        cen_prev = cen;
    end

    // miso monitor: bits on sclk rises 25..32 form the returned byte.
    int         rise_cnt = 0;
    logic [7:0] rx_byte  = 8'h00;
    logic [7:0] rx_e;
    always @(posedge sclk, posedge csn) begin
        if (csn === 1'b1) begin
            if (rise_cnt >= 32) begin
                check("rx_expected", 32'(rx_q.size() != 0), 32'd1);
                if (rx_q.size() != 0) begin
                    rx_e = rx_q.pop_front();
                    check("miso_byte", 32'(rx_byte), 32'(rx_e));
                end
            end
            rise_cnt = 0;
        end else begin
            rise_cnt++;
            if (rise_cnt >= 25 && rise_cnt <= 32) rx_byte = {rx_byte[6:0], miso};
        end
    end

    // SPI mode-0 master. early_csn raises csn one clk after the last rise.
    task automatic spi_frame(input logic [23:0] h, input logic [7:0] wb, input int nbits,
                             input bit hold_csn, input bit early_csn);
        logic [39:0] tx;
        tx = {h, wb, 8'h00};
        @(negedge clk);
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[39-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (early_csn && i == nbits - 1) begin
                @(negedge clk);
                csn = 1'b1;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
        if (!hold_csn && !early_csn) begin
            repeat (HALF) @(negedge clk);
            csn = 1'b1;
        end
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic exp_read(input logic [16:0] a, input logic [7:0] b, input bit full);
        acc_t e;
        e.addr = a; e.data = b; e.width = 2;
        rd_q.push_back(e);
        if (full) rx_q.push_back(b);
        exp_acc++;
    endtask

    task automatic exp_write(input logic [16:0] a, input logic [7:0] b);
        acc_t e;
        e.addr = a; e.data = b; e.width = 2;
        wr_q.push_back(e);
        rx_q.push_back(8'h00);
        exp_acc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},  32'(cen),  32'd1);
        check({tag, "_oen"},  32'(oen),  32'd1);
        check({tag, "_wen"},  32'(wen),  32'd1);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_data_z"}, {24'h0, data}, {24'h0, 8'hzz});
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Plain read.
        sram_byte = 8'h96;
        exp_read(17'h139c6, 8'h96, 1'b1);
        spi_frame(hdr(2'b10, 5'b00000, 17'h139c6), 8'h00, 32, 1'b0, 1'b0);
        check("addr_held", 32'(addr), 32'h139c6);

        // Write with non-zero pad bits.
        exp_write(17'h00001, 8'h5A);
        spi_frame(hdr(2'b11, 5'b10101, 17'h00001), 8'h5A, 32, 1'b0, 1'b0);

        // Unsupported command: no SRAM cycle, miso stays 0.
        rx_q.push_back(8'h00);
        spi_frame(hdr(2'b01, 5'b00000, 17'h1FFFF), 8'hFF, 32, 1'b0, 1'b0);
        check("addr_after_ignore", 32'(addr), 32'h00001);

        // Header aborted after 12 bits, then a complete read.
        spi_frame(hdr(2'b10, 5'b00000, 17'h1FFFF), 8'h00, 12, 1'b0, 1'b0);
        sram_byte = 8'hC3;
        exp_read(17'h1FFFF, 8'hC3, 1'b1);
        spi_frame(hdr(2'b10, 5'b00000, 17'h1FFFF), 8'h00, 32, 1'b0, 1'b0);

        // Reset in the middle of read data output.
        sram_byte = 8'hB9;
        exp_read(17'h12345, 8'hB9, 1'b0);
        spi_frame(hdr(2'b10, 5'b00000, 17'h12345), 8'h00, 27, 1'b1, 1'b0);
        check("miso_before_rst", 32'(miso), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        sram_byte = 8'h3C;
        exp_read(17'h0ABCD, 8'h3C, 1'b1);
        spi_frame(hdr(2'b10, 5'b00000, 17'h0ABCD), 8'h00, 40, 1'b0, 1'b0);

        // csn rises while the write pulse runs; next frame proves IDLE.
        exp_write(17'h0F0F0, 8'hA5);
        spi_frame(hdr(2'b11, 5'b00000, 17'h0F0F0), 8'hA5, 32, 1'b0, 1'b1);
        sram_byte = 8'h81;
        exp_read(17'h00042, 8'h81, 1'b1);
        spi_frame(hdr(2'b10, 5'b00000, 17'h00042), 8'h00, 32, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        check("sram_cycles", 32'(cen_falls), 32'(exp_acc));
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rx_q_drained", 32'(rx_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_sram_bridge.md
SPI_SRAM_BRIDGE -- requirements
Module: spi_sram_bridge

Interface
REQ-001 Parameter RD_WAIT, default 2: clk cycles from oen/cen low to data latch.
REQ-002 Parameter WR_PULSE, default 2: clk cycles wen is held low.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sclk  in  1  SPI clock from the master, asynchronous to clk, mode 0.
REQ-006 csn  in  1  SPI chip select, active low, asynchronous.
REQ-007 mosi  in  1  SPI data in, MSB first.
REQ-008 miso  out  1  SPI data out, MSB first.
REQ-009 cen  out  1  SRAM chip enable, active low.
REQ-010 oen  out  1  SRAM output enable, active low.
REQ-011 wen  out  1  SRAM write enable, active low.
REQ-012 addr  out  17  SRAM address.
REQ-013 data  inout  8  SRAM data bus; driven only during writes, else high-Z.

Function
REQ-014 sclk, csn and mosi SHALL pass through a 2-flop synchroniser; sclk edges SHALL be detected on the synchronised signal; sclk SHALL be at most clk/8.
REQ-015 A frame SHALL begin on a synchronised csn fall and carry a 24-bit header {cmd[1:0], pad[4:0], addr[16:0]}, one bit per sclk rise.
REQ-016 cmd 2'b10 = READ, 2'b11 = WRITE; pad bits SHALL be ignored; any other cmd SHALL produce no SRAM activity until csn rises.
REQ-017 States: IDLE, HDR, RD_ACC, RD_OUT, WR_DATA, WR_PULSE, IGNORE.
REQ-018 IDLE->HDR on csn fall; HDR->RD_ACC / WR_DATA / IGNORE on the 24th sclk rise, according to cmd.
REQ-019 RD_ACC: addr SHALL be loaded on entry; cen and oen SHALL go low on the next clk; data SHALL be latched RD_WAIT clks later; cen and oen SHALL then return high, followed by ->RD_OUT.
REQ-020 RD_OUT: bit 7 of the latched byte SHALL be driven on miso at the sclk fall following the 24th rise; each later sclk fall SHALL shift the next bit; after 8 bits ->IGNORE.
REQ-021 Read timing: synchroniser delay (2) + 1 + RD_WAIT clks SHALL be less than one sclk half period.
REQ-022 WR_DATA: 8 bits SHALL be sampled on sclk rises; on the 8th bit ->WR_PULSE.
REQ-023 WR_PULSE: data SHALL be driven with the byte and cen low for WR_PULSE+2 clks; wen SHALL be low for the middle WR_PULSE clks; then all controls SHALL release and ->IGNORE.
REQ-024 IGNORE: no SRAM activity; miso SHALL be held 0; ->IDLE on csn rise.
REQ-025 csn rise in HDR, RD_ACC, RD_OUT or WR_DATA SHALL abort the frame and release cen/oen/wen within 1 clk.
REQ-026 csn rise in WR_PULSE SHALL complete the write, then ->IDLE.
REQ-027 miso SHALL be 0 whenever the state is not RD_OUT.
REQ-028 The bit counter SHALL be 6 bits; extra sclk edges after 24 header bits + 8 data bits SHALL be ignored.
REQ-029 addr SHALL hold its last value between frames.

Reset
REQ-030 On rst high at a clk edge, all outputs SHALL take reset values on that edge.
REQ-031 Reset values: state IDLE, cen=1, oen=1, wen=1, addr=0, miso=0, data high-Z, shift and bit counters 0.
REQ-032 A frame interrupted by rst SHALL be discarded; the next valid frame SHALL start only after a fresh csn fall.

Structure
REQ-033 Package spi_sram_pkg SHALL hold CMD_READ, CMD_WRITE, HDR_BITS=24, ADDR_W=17, DATA_W=8 and the state encoding.
REQ-034 One sub-module, spi_sync_edge, SHALL synchronise sclk/csn/mosi and produce sclk_rise, sclk_fall, csn_fall and csn_rise pulses.

Verification
REQ-035 READ of addr 17'h139c6, SRAM model driving 8'h96 while oen is low -> addr=17'h139c6; cen and oen low for RD_WAIT clks; miso bits 1,0,0,1,0,1,1,0 sampled on the 8 sclk rises.
REQ-036 WRITE of addr 17'h00001, data 8'h5A -> wen low exactly 2 clks; data=8'h5A and addr=17'h00001 stable throughout the wen-low window; oen stays high.
REQ-037 Header with cmd 2'b01 at addr 17'h1FFFF followed by 8 clocks -> cen, oen and wen never go low; miso stays 0.
REQ-038 csn rises after 12 header bits, then a full READ of 17'h1FFFF -> no SRAM activity from the first frame; the second frame returns the model byte correctly.
REQ-039 rst pulsed during RD_OUT after 3 bits -> all outputs at reset values the next clk; the following READ completes normally.
REQ-040 csn rises during WR_PULSE -> full wen pulse still completes; state returns to IDLE.
